mult_seq_redundant: RTL and testbench
=====================================

Name: mult_seq_redundant

Overview:
- Iterative, handshaked successor to the combinational redundant-word multiplier.
- Accepts two NUM_ELEMENTS-word operands. Each word is BIT_LEN wide at WORD_LEN weight, so inputs may be redundant (BIT_LEN > WORD_LEN).
- Multiplies one B row per cycle into a column accumulator, then ripples carries one column per cycle to produce a canonical 2*NUM_ELEMENTS-word product.
- Adds square mode, abort, and valid/ready flow control. Sits in the big-integer datapath between operand staging and the reduction unit.

Parameters:
- NUM_ELEMENTS, 17, number of input words per operand
- BIT_LEN, 17, width of each input word (redundant; at least WORD_LEN)
- WORD_LEN, 16, weight step between words, and width of each output word
- ACC_W, 2*BIT_LEN+$clog2(NUM_ELEMENTS)+1, column accumulator width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- sq  in  1  square mode; B ignored, A used for both operands; sampled with operands
- a  in  [BIT_LEN-1:0] x NUM_ELEMENTS  operand A (unpacked array)
- b  in  [BIT_LEN-1:0] x NUM_ELEMENTS  operand B (unpacked array)
- abort  in  1  synchronous cancel of the current operation
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- m  out  [WORD_LEN-1:0] x 2*NUM_ELEMENTS  canonical product words, word k weight 2^(WORD_LEN*k)
- m_top  out  ACC_W-WORD_LEN  residual carry above word 2*NUM_ELEMENTS-1; zero for canonical inputs
- busy  out  1  high in MUL or NORM

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE; in_ready=1; out_valid=0; busy=0; m, m_top, column accumulator, and counters all 0.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready:
  - latch a, and b (or a if sq=1);
  - clear all columns, row counter j=0;
  - go to MUL.
- MUL, NUM_ELEMENTS cycles: for every i, col[i+j] += A[i]*B[j] (full 2*BIT_LEN-bit product, ACC_W-bit add). Increment j; after j=NUM_ELEMENTS-1, go to NORM with k=0 and carry=0.
- NORM, 2*NUM_ELEMENTS cycles: t=col[k]+carry; m[k]<=t[WORD_LEN-1:0]; carry<=t>>WORD_LEN; increment k. After the last column, m_top<=final carry and go to DONE.
- DONE: out_valid=1. m and m_top are held stable while out_ready=0. On out_ready=1: out_valid=0, go to IDLE.
  - in_ready is 0 in DONE, so no overlap.
  - Next accept is earliest on the cycle after the output handshake.
- Latency: accept edge to out_valid high is exactly 3*NUM_ELEMENTS+1 cycles.
- in_ready is 0 in MUL, NORM, and DONE. in_valid in those states is ignored (not queued).
- abort=1 in MUL or NORM: next state IDLE, out_valid stays 0, m and m_top unchanged. abort in IDLE or DONE has no effect; DONE must still complete via out_ready.
- abort and in_valid both high in IDLE: accept wins.
- Width: ACC_W guarantees no column overflow. Column sum is at most NUM_ELEMENTS*(2^BIT_LEN-1)^2 plus carry-in. Value identity: sum m[k]*2^(WORD_LEN*k) + m_top*2^(WORD_LEN*2*NUM_ELEMENTS) == A*B, where A = sum a[i]*2^(WORD_LEN*i).
- rst_n asserted mid-operation: immediate return to reset values. No partial output is ever flagged valid.

Decomposition:
- Package mult_seq_pkg:
  - state enum type (IDLE, MUL, NORM, DONE);
  - function acc_width(bit_len, num_elements);
  - typedefs for the word array and column array types.
- Sub-module mult_row_mac: combinational row of NUM_ELEMENTS BIT_LEN x BIT_LEN multipliers. Returns the updated column vector for a given B word and row index.
- FSM, counters, and the NORM ripple stay in mult_seq_redundant.

Test Plan:
- A=0, B=0, out_ready=1 -> out_valid rises exactly 52 cycles after accept; all m=0, m_top=0; in_ready high the following cycle.
- All a[i]=b[i]=16'hFFFF (value 2^272-1) -> m[0]=16'h0001, m[1..16]=0, m[17]=16'hFFFE, m[18..33]=16'hFFFF, m_top=0.
- sq=1, a[0]=3, others 0, b random -> m[0]=9, all other words 0, m_top=0.
- Redundant input a[16]=b[16]=17'h1FFFF, others 0 -> product (2^17-1)^2 * 2^512 lands in m_top, m[32..33] with m_top nonzero. Random compare against a 600-bit golden model for 300 operations.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, m, m_top stable; in_ready=0; in_valid pulse ignored. Second operation accepted the cycle after the handshake.
- abort in MUL cycle 4, then separately rst_n low in NORM -> state IDLE; out_valid never rises; in_ready=1 next cycle (abort) or immediately (reset). A following operation gives the correct result.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// Shared types and width helpers for the sequential redundant-word multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  localparam int DEF_NUM_ELEMENTS = 17;
  localparam int DEF_BIT_LEN      = 17;
  localparam int DEF_WORD_LEN     = 16;

  // Column width: full BIT_LEN x BIT_LEN product, growth from summing
  // NUM_ELEMENTS of them, plus one bit of headroom for the ripple carry-in.
  function automatic int acc_width(input int bit_len, input int num_elements);
    return 2 * bit_len + $clog2(num_elements) + 1;
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_BIT_LEN, DEF_NUM_ELEMENTS);

  typedef logic [DEF_BIT_LEN-1:0] word_arr_t [DEF_NUM_ELEMENTS];
  typedef logic [DEF_ACC_W-1:0]   col_arr_t  [2*DEF_NUM_ELEMENTS];

endpackage

// File: rtl/mult_row_mac.sv
// One partial-product row: multiplies every A word by a single B word and
// adds the products into the column vector, offset by the row index.
module mult_row_mac
  import mult_seq_pkg::*;
#(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int ACC_W        = acc_width(BIT_LEN, NUM_ELEMENTS),
  parameter int JW           = 5
) (
  input  logic [BIT_LEN-1:0] a       [NUM_ELEMENTS],
  input  logic [BIT_LEN-1:0] b_word,
  input  logic [JW-1:0]      row,
  input  logic [ACC_W-1:0]   col_in  [2*NUM_ELEMENTS],
  output logic [ACC_W-1:0]   col_out [2*NUM_ELEMENTS]
);

  logic [2*BIT_LEN-1:0] prod [NUM_ELEMENTS];

  for (genvar gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_mul
    assign prod[gi] = {{BIT_LEN{1'b0}}, a[gi]} * {{BIT_LEN{1'b0}}, b_word};
  end

  // Each column picks the single product whose index lands on it this row.
  for (genvar gi = 0; gi < 2*NUM_ELEMENTS; gi++) begin : g_col
    logic [2*BIT_LEN-1:0] addend;
    always_comb begin
      addend = '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        if (i + int'(row) == gi) addend = prod[i];
      end
    end
    assign col_out[gi] = col_in[gi] + ACC_W'(addend);
  end

endmodule

// File: rtl/mult_seq_redundant.sv
// Iterative redundant-word multiplier: one B row per cycle into a column
// accumulator, then a one-column-per-cycle carry ripple to canonical words.
module mult_seq_redundant
  import mult_seq_pkg::*;
#(
  parameter int NUM_ELEMENTS = 17,
  parameter int BIT_LEN      = 17,
  parameter int WORD_LEN     = 16,
  parameter int ACC_W        = acc_width(BIT_LEN, NUM_ELEMENTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sq,
  input  logic [BIT_LEN-1:0]        a     [NUM_ELEMENTS],
  input  logic [BIT_LEN-1:0]        b     [NUM_ELEMENTS],
  input  logic                      abort,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_LEN-1:0]       m     [2*NUM_ELEMENTS],
  output logic [ACC_W-WORD_LEN-1:0] m_top,
  output logic                      busy
);

  localparam int NCOL = 2 * NUM_ELEMENTS;
  localparam int JW   = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int KW   = $clog2(NCOL + 1);
  localparam int CW   = ACC_W - WORD_LEN;

  state_t               state_reg, state_next;
  logic [BIT_LEN-1:0]   a_reg     [NUM_ELEMENTS];
  logic [BIT_LEN-1:0]   b_reg     [NUM_ELEMENTS];
  logic [ACC_W-1:0]     col_reg   [NCOL];
  logic [ACC_W-1:0]     col_next  [NCOL];
  logic [WORD_LEN-1:0]  m_reg     [NCOL];
  logic [CW-1:0]        m_top_reg;
  logic [CW-1:0]        carry_reg;
  logic [JW-1:0]        j_reg;
  logic [KW-1:0]        k_reg;
  logic [ACC_W-1:0]     norm_sum;
  logic                 k_in_range;

  mult_row_mac #(
    .NUM_ELEMENTS (NUM_ELEMENTS),
    .BIT_LEN      (BIT_LEN),
    .ACC_W        (ACC_W),
    .JW           (JW)
  ) u_row_mac (
    .a       (a_reg),
    .b_word  (b_reg[j_reg]),
    .row     (j_reg),
    .col_in  (col_reg),
    .col_out (col_next)
  );

  // k_reg == NCOL is the extra cycle that commits the residual carry to m_top.
  assign k_in_range = (k_reg < KW'(NCOL));
  assign norm_sum   = k_in_range ? (col_reg[k_reg] + ACC_W'(carry_reg)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (abort)                                 state_next = IDLE;
        else if (j_reg == JW'(NUM_ELEMENTS - 1))   state_next = NORM;
      end
      NORM: begin
        busy = 1'b1;
        if (abort)                  state_next = IDLE;
        else if (!k_in_range)       state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        a_reg[i] <= '0;
        b_reg[i] <= '0;
      end
      for (int i = 0; i < NCOL; i++) begin
        col_reg[i] <= '0;
        m_reg[i]   <= '0;
      end
      m_top_reg <= '0;
      carry_reg <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
              a_reg[i] <= a[i];
              b_reg[i] <= sq ? a[i] : b[i];
            end
            for (int i = 0; i < NCOL; i++) col_reg[i] <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            carry_reg <= '0;
          end
        end
        MUL: begin
          if (!abort) begin
            col_reg <= col_next;
            j_reg   <= j_reg + JW'(1);
          end
        end
        NORM: begin
          // An aborted cycle leaves the output words untouched.
          if (!abort) begin
            if (k_in_range) begin
              m_reg[k_reg] <= norm_sum[WORD_LEN-1:0];
              carry_reg    <= norm_sum[ACC_W-1:WORD_LEN];
              k_reg        <= k_reg + KW'(1);
            end else begin
              m_top_reg <= carry_reg;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NCOL; gi++) begin : g_out
    assign m[gi] = m_reg[gi];
  end
  assign m_top = m_top_reg;

endmodule

// File: tb/tb_mult_seq_redundant.sv
// Scoreboard bench for mult_seq_redundant: table vectors, random operands
// against a wide-integer golden product, and handshake/abort/reset sequences.
module tb_mult_seq_redundant;
  import mult_seq_pkg::*;

  localparam int N    = 17;
  localparam int BL   = 17;
  localparam int WL   = 16;
  localparam int NCOL = 2 * N;
  localparam int AW   = 2 * BL + $clog2(N) + 1;
  localparam int TW   = AW - WL;
  localparam int PW   = 600;
  localparam int FW   = N * BL;
  localparam int LAT  = 3 * N + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic sq = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  word_arr_t a, b;
  logic [WL-1:0] m [NCOL];
  logic [TW-1:0] m_top;

  always #5 clk = ~clk;

  mult_seq_redundant dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sq        (sq),
    .a         (a),
    .b         (b),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .m         (m),
    .m_top     (m_top),
    .busy      (busy)
  );

  typedef struct {
    logic          sq;
    logic [FW-1:0] af;
    logic [FW-1:0] bf;
    logic [PW-1:0] e;
  } vec_t;

  vec_t          tbl [6];
  int            n_checks = 0;
  int            n_err = 0;
  logic [PW-1:0] exp_q [$];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] to_val(input logic [FW-1:0] f);
    logic [PW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v = v + (PW'(f[BL*i +: BL]) << (WL*i));
    return v;
  endfunction

  function automatic logic [PW-1:0] golden(input logic [FW-1:0] af, input logic [FW-1:0] bf, input logic s);
    logic [PW-1:0] av, bv;
    av = to_val(af);
    bv = s ? av : to_val(bf);
    return av * bv;
  endfunction

  function automatic logic [PW-1:0] dut_value();
    logic [PW-1:0] v;
    v = '0;
    for (int k = 0; k < NCOL; k++) v = v | (PW'(m[k]) << (WL*k));
    v = v | (PW'(m_top) << (WL*NCOL));
    return v;
  endfunction

  function automatic logic [FW-1:0] rand_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[BL*i +: BL] = BL'($urandom_range(0, (1 << BL) - 1));
    return f;
  endfunction

  function automatic logic [FW-1:0] fill_all(input logic [BL-1:0] w);
    logic [FW-1:0] f;
    for (int i = 0; i < N; i++) f[BL*i +: BL] = w;
    return f;
  endfunction

  // Scoreboard: compare whenever a product is about to be handshaken.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got out_valid=1, required no pending product");
      end else begin
        check("product", dut_value(), exp_q.pop_front());
      end
    end
  end

  task automatic start(input logic [FW-1:0] af, input logic [FW-1:0] bf, input logic s,
                       input logic ab, input logic push, input logic [PW-1:0] e);
    for (int i = 0; i < N; i++) begin
      a[i] = af[BL*i +: BL];
      b[i] = bf[BL*i +: BL];
    end
    sq    = s;
    abort = ab;
    check("in_ready_before_accept", PW'(in_ready), 1);
    in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input logic [FW-1:0] af, input logic [FW-1:0] bf, input logic s,
                       input logic ab, input logic [PW-1:0] e);
    int cyc;
    start(af, bf, s, ab, 1'b1, e);
    wait_out(cyc);
    check("latency", PW'(cyc), LAT);
    if (cyc >= 200) exp_q.delete();
    @(posedge clk); #1;
    check("in_ready_after_handshake", PW'(in_ready), 1);
    check("out_valid_after_handshake", PW'(out_valid), 0);
  endtask

  initial begin
    logic [PW-1:0] one, e, last_e;
    logic [FW-1:0] af, bf, zf;
    int            cyc;
    logic          seen;

    one = 1;
    zf  = '0;

    tbl[0] = '{sq: 1'b0, af: zf, bf: zf, e: '0};
    tbl[1] = '{sq: 1'b0, af: fill_all(17'h0FFFF), bf: fill_all(17'h0FFFF),
               e: (one << 544) - (one << 273) + one};
    af = zf; af[BL-1:0] = 17'd3;
    tbl[2] = '{sq: 1'b1, af: af, bf: rand_flat(), e: 600'd9};
    af = zf; af[BL*16 +: BL] = 17'h1FFFF;
    tbl[3] = '{sq: 1'b0, af: af, bf: af, e: ((one << 34) - (one << 18) + one) << 512};
    af = zf; af[BL-1:0] = 17'h1FFFF;
    tbl[4] = '{sq: 1'b0, af: af, bf: af, e: (one << 34) - (one << 18) + one};
    bf = zf; bf[BL-1:0] = 17'd1;
    e  = '0;
    for (int i = 0; i < N; i++) e = e + ((one << 17) - one << (WL*i));
    tbl[5] = '{sq: 1'b0, af: fill_all(17'h1FFFF), bf: bf, e: e};

    #3;
    check("reset_in_ready", PW'(in_ready), 1);
    check("reset_out_valid", PW'(out_valid), 0);
    check("reset_busy", PW'(busy), 0);
    check("reset_outputs", dut_value(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) do_op(tbl[v].af, tbl[v].bf, tbl[v].sq, 1'b0, tbl[v].e);

    // Accept wins over a simultaneous abort in IDLE.
    af = rand_flat(); bf = rand_flat();
    do_op(af, bf, 1'b0, 1'b1, golden(af, bf, 1'b0));

    for (int n = 0; n < 300; n++) begin
      logic s;
      af = rand_flat(); bf = rand_flat();
      s  = ($urandom_range(0, 7) == 0);
      do_op(af, bf, s, 1'b0, golden(af, bf, s));
    end

    // Backpressure: hold DONE, poke in_valid and abort, then release.
    out_ready = 1'b0;
    af = rand_flat(); bf = rand_flat();
    e  = golden(af, bf, 1'b0);
    start(af, bf, 1'b0, 1'b0, 1'b1, e);
    wait_out(cyc);
    check("bp_latency", PW'(cyc), LAT);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        a[0] = 17'h1234;
        in_valid = 1'b1;
      end
      if (c == 3) abort = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      abort    = 1'b0;
      check("bp_out_valid", PW'(out_valid), 1);
      check("bp_in_ready", PW'(in_ready), 0);
      check("bp_busy", PW'(busy), 0);
      check("bp_hold_value", dut_value(), e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after", PW'(in_ready), 1);
    last_e = golden(zf, zf, 1'b0);
    af = fill_all(17'h0FFFF); bf = zf; bf[BL-1:0] = 17'd2;
    last_e = golden(af, bf, 1'b0);
    do_op(af, bf, 1'b0, 1'b0, last_e);

    // Abort on the fourth MUL cycle.
    start(rand_flat(), rand_flat(), 1'b0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_in_ready", PW'(in_ready), 1);
    check("abort_busy", PW'(busy), 0);
    check("abort_outputs_kept", dut_value(), last_e);
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", PW'(seen), 0);
    af = rand_flat(); bf = rand_flat();
    do_op(af, bf, 1'b0, 1'b0, golden(af, bf, 1'b0));

    // Reset during NORM.
    start(rand_flat(), rand_flat(), 1'b0, 1'b0, 1'b0, '0);
    repeat (N + 5) @(posedge clk);
    #1;
    check("norm_busy", PW'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", PW'(in_ready), 1);
    check("rst_out_valid", PW'(out_valid), 0);
    check("rst_busy", PW'(busy), 0);
    check("rst_outputs", dut_value(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    af = rand_flat(); bf = rand_flat();
    do_op(af, bf, 1'b1, 1'b0, golden(af, bf, 1'b1));

    repeat (3) @(posedge clk);
    check("scoreboard_drained", PW'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no completion, required finish within 5 ms");
    $fatal(1, "timeout");
  end

endmodule
